painterengine_gpu_dma_reader: RTL and testbench

//  Responder for the display controller's DMA reader command interface: takes (address, length, resetn) and fetches length 32-bit words.

---
 rtl/painterengine_gpu_dma_reader.sv | 164 ++++++++++++++++
 tb/tb_painterengine_gpu_dma_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 INCR-burst DMA reader: fetches `length` words from `address`, one burst in flight, split at 4KB pages.
// Words stream out combinationally from R (rready follows data_next); done/error register one cycle after the last beat.
module painterengine_gpu_dma_reader #(
  parameter int unsigned PARAM_MAX_BURST = 16
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_reader_resetn,
  input  logic [31:0] i_wire_reader_address,
  input  logic [31:0] i_wire_reader_length,
  output logic        o_wire_reader_done,
  output logic        o_wire_reader_error,
  output logic [31:0] o_wire_reader_data,
  output logic        o_wire_reader_data_valid,
  input  logic        i_wire_reader_data_next,
  output logic [31:0] o_wire_m_axi_araddr,
  output logic [7:0]  o_wire_m_axi_arlen,
  output logic [2:0]  o_wire_m_axi_arsize,
  output logic [1:0]  o_wire_m_axi_arburst,
  output logic        o_wire_m_axi_arvalid,
  input  logic        i_wire_m_axi_arready,
  input  logic [31:0] i_wire_m_axi_rdata,
  input  logic [1:0]  i_wire_m_axi_rresp,
  input  logic        i_wire_m_axi_rlast,
  input  logic        i_wire_m_axi_rvalid,
  output logic        o_wire_m_axi_rready
);

  localparam logic [31:0] MAX_BURST = 32'(PARAM_MAX_BURST);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] remaining_q;
  logic [31:0] beats_q;
  logic [31:0] beat_cnt_q;
  logic        err_q;

  logic [31:0] page_room;
  logic [31:0] beats_c;
  logic [31:0] beat_cnt_inc;
  logic [31:0] rem_dec;
  logic        resp_bad;
  logic        beat_acc;
  logic        beat_err;
  logic        err_d;

  // Beats that still fit in the current 4KB page.
  assign page_room    = 32'((13'd4096 - {1'b0, addr_q[11:0]}) >> 2);
  assign beat_cnt_inc = beat_cnt_q + 32'd1;
  assign rem_dec      = remaining_q - 32'd1;
  assign resp_bad     = (i_wire_m_axi_rresp != 2'b00);

  always_comb begin
    beats_c = remaining_q;
    if (MAX_BURST < beats_c) beats_c = MAX_BURST;
    if (page_room < beats_c) beats_c = page_room;
  end

  assign beat_acc = (state_q == ST_DATA) && i_wire_m_axi_rvalid && o_wire_m_axi_rready;
  assign beat_err = beat_acc && (resp_bad ||
                                 ( i_wire_m_axi_rlast && (beat_cnt_inc != beats_q)) ||
                                 (!i_wire_m_axi_rlast && (beat_cnt_inc == beats_q)));
  assign err_d    = err_q || beat_err;

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'd0;
      remaining_q <= 32'd0;
      beats_q     <= 32'd0;
      beat_cnt_q  <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && i_wire_reader_resetn) begin
        addr_q      <= i_wire_reader_address;
        remaining_q <= i_wire_reader_length;
        err_q       <= 1'b0;
      end
      if ((state_q == ST_ADDR) && i_wire_m_axi_arready) begin
        beats_q    <= beats_c;
        beat_cnt_q <= 32'd0;
        err_q      <= 1'b0;
      end
      if (beat_acc) begin
        addr_q      <= addr_q + 32'd4;
        remaining_q <= rem_dec;
        beat_cnt_q  <= beat_cnt_inc;
        err_q       <= err_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_wire_reader_resetn) begin
          if (i_wire_reader_address[1:0] != 2'b00) state_d = ST_ERROR;
          else if (i_wire_reader_length == 32'd0)  state_d = ST_DONE;
          else                                     state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (i_wire_m_axi_arready) state_d = i_wire_reader_resetn ? ST_DATA : ST_DRAIN;
      end
      ST_DATA: begin
        // An abort coinciding with rlast has nothing left to drain.
        if (!i_wire_reader_resetn) begin
          state_d = (beat_acc && i_wire_m_axi_rlast) ? ST_IDLE : ST_DRAIN;
        end else if (beat_acc && i_wire_m_axi_rlast) begin
          if (err_d)                  state_d = ST_ERROR;
          else if (rem_dec == 32'd0)  state_d = ST_DONE;
          else                        state_d = ST_ADDR;
        end
      end
      ST_DRAIN: begin
        if (i_wire_m_axi_rvalid && i_wire_m_axi_rlast) state_d = ST_IDLE;
      end
      ST_DONE, ST_ERROR: begin
        if (!i_wire_reader_resetn) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_wire_m_axi_araddr      = addr_q;
    o_wire_m_axi_arlen       = 8'(beats_c - 32'd1);
    o_wire_m_axi_arsize      = 3'b010;
    o_wire_m_axi_arburst     = 2'b01;
    o_wire_m_axi_arvalid     = 1'b0;
    o_wire_m_axi_rready      = 1'b0;
    o_wire_reader_data_valid = 1'b0;
    o_wire_reader_done       = 1'b0;
    o_wire_reader_error      = 1'b0;
    case (state_q)
      ST_ADDR:  o_wire_m_axi_arvalid = 1'b1;
      ST_DATA: begin
        // Once a burst has failed, swallow its remaining beats regardless of the consumer.
        o_wire_m_axi_rready      = err_q || i_wire_reader_data_next ||
                                   (i_wire_m_axi_rvalid && resp_bad);
        o_wire_reader_data_valid = i_wire_m_axi_rvalid && i_wire_reader_data_next &&
                                   !err_q && !resp_bad;
      end
      ST_DRAIN: o_wire_m_axi_rready = 1'b1;
      ST_DONE:  o_wire_reader_done  = 1'b1;
      ST_ERROR: o_wire_reader_error = 1'b1;
      default: ;
    endcase
  end

  assign o_wire_reader_data = i_wire_m_axi_rdata;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Directed bench for painterengine_gpu_dma_reader: AXI read slave model plus consumer scoreboard.
module tb_painterengine_gpu_dma_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        resetn;
  logic [31:0] address;
  logic [31:0] length;
  logic        done, error;
  logic [31:0] data;
  logic        data_valid;
  logic        data_next;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  painterengine_gpu_dma_reader #(.PARAM_MAX_BURST(16)) dut (
    .i_wire_clock             (clk),
    .i_wire_reset             (rst),
    .i_wire_reader_resetn     (resetn),
    .i_wire_reader_address    (address),
    .i_wire_reader_length     (length),
    .o_wire_reader_done       (done),
    .o_wire_reader_error      (error),
    .o_wire_reader_data       (data),
    .o_wire_reader_data_valid (data_valid),
    .i_wire_reader_data_next  (data_next),
    .o_wire_m_axi_araddr      (araddr),
    .o_wire_m_axi_arlen       (arlen),
    .o_wire_m_axi_arsize      (arsize),
    .o_wire_m_axi_arburst     (arburst),
    .o_wire_m_axi_arvalid     (arvalid),
    .i_wire_m_axi_arready     (arready),
    .i_wire_m_axi_rdata       (rdata),
    .i_wire_m_axi_rresp       (rresp),
    .i_wire_m_axi_rlast       (rlast),
    .i_wire_m_axi_rvalid      (rvalid),
    .o_wire_m_axi_rready      (rready)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  // slave / consumer model state
  bit          rand_mode = 1'b0;
  int          err_beat = -1;
  bit          burst_active = 1'b0;
  logic [31:0] cur_addr = 32'd0;
  int          beats_left = 0;
  int          gbeat = 0;
  int          ar_cnt = 0;
  logic [31:0] ar_addr_log [8];
  logic [7:0]  ar_len_log  [8];
  int          words = 0;
  logic [31:0] exp_base = 32'd0;
  int          data_bad = 0, dv_bad = 0, both_bad = 0, stable_bad = 0;
  int          ar_overlap = 0, ar_fmt_bad = 0;
  int          last_dv_cyc = -1, done_cyc = -1;
  int          cyc = 0;
  bit          ar_hold = 1'b0;
  logic [31:0] held_addr = 32'd0;
  logic [7:0]  held_len = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; data_next = 1'b0;
    forever begin
      @(negedge clk);
      arready   = burst_active ? 1'b0 : (rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (burst_active) begin
        rvalid = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        rdata  = mem_word(cur_addr);
        rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
        rlast  = (beats_left == 1);
      end else begin
        rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;
      end
      data_next = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (arvalid && burst_active) ar_overlap++;
      if (ar_hold && arvalid && (araddr !== held_addr || arlen !== held_len)) stable_bad++;
      ar_hold   = arvalid && !arready;
      held_addr = araddr;
      held_len  = arlen;
      if (data_valid) begin
        if (!(rvalid && rready)) dv_bad++;
        if (data !== mem_word(exp_base + 32'(4 * words))) data_bad++;
        words++;
        last_dv_cyc = cyc;
      end
      if (arvalid && arready) begin
        if (ar_cnt < 8) begin
          ar_addr_log[ar_cnt] = araddr;
          ar_len_log[ar_cnt]  = arlen;
        end
        ar_cnt++;
        if (arsize !== 3'b010 || arburst !== 2'b01) ar_fmt_bad++;
        burst_active = 1'b1;
        cur_addr     = araddr;
        beats_left   = int'(arlen) + 1;
      end
      if (rvalid && rready) begin
        cur_addr = cur_addr + 32'd4;
        beats_left--;
        gbeat++;
        if (beats_left == 0) burst_active = 1'b0;
      end
      if (done && error) both_bad++;
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic start_cmd(input logic [31:0] a, input logic [31:0] len, output int c0);
    @(negedge clk);
    ar_cnt = 0; words = 0; gbeat = 0; data_bad = 0; stable_bad = 0;
    last_dv_cyc = -1; done_cyc = -1; exp_base = a;
    address = a; length = len; resetn = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_end(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (done || error) begin ok = 1'b1; break; end
    end
    check({tag, "_finished"}, 32'(ok), 32'd1);
  endtask

  task automatic stop_cmd();
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; resetn = 1'b0; address = 32'd0; length = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #2;
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_dvalid", 32'(data_valid), 32'd0);

    // 40 words from 0x1000: bursts 16,16,8
    start_cmd(32'h1000, 32'd40, c0);
    wait_end("t1", 500);
    check("t1_ar_cnt", 32'(ar_cnt), 32'd3);
    check("t1_ar0_addr", ar_addr_log[0], 32'h1000);
    check("t1_ar1_addr", ar_addr_log[1], 32'h1040);
    check("t1_ar2_addr", ar_addr_log[2], 32'h1080);
    check("t1_ar0_len", 32'(ar_len_log[0]), 32'd15);
    check("t1_ar1_len", 32'(ar_len_log[1]), 32'd15);
    check("t1_ar2_len", 32'(ar_len_log[2]), 32'd7);
    check("t1_words", 32'(words), 32'd40);
    check("t1_data", 32'(data_bad), 32'd0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_done_lat", 32'(done_cyc - last_dv_cyc), 32'd1);
    stop_cmd();
    check("t1_done_clear", 32'(done), 32'd0);

    // 4KB page split
    start_cmd(32'h0FF8, 32'd8, c0);
    wait_end("t2", 300);
    check("t2_ar_cnt", 32'(ar_cnt), 32'd2);
    check("t2_ar0_addr", ar_addr_log[0], 32'h0FF8);
    check("t2_ar0_len", 32'(ar_len_log[0]), 32'd1);
    check("t2_ar1_addr", ar_addr_log[1], 32'h1000);
    check("t2_ar1_len", 32'(ar_len_log[1]), 32'd5);
    check("t2_words", 32'(words), 32'd8);
    check("t2_data", 32'(data_bad), 32'd0);
    check("t2_done", 32'(done), 32'd1);
    stop_cmd();

    // zero length
    start_cmd(32'h2000, 32'd0, c0);
    wait_end("t3", 20);
    check("t3_done", 32'(done), 32'd1);
    check("t3_done_lat", 32'(done_cyc - c0), 32'd1);
    check("t3_ar_cnt", 32'(ar_cnt), 32'd0);
    stop_cmd();

    // misaligned address
    start_cmd(32'h1002, 32'd4, c0);
    wait_end("t4", 20);
    check("t4_error", 32'(error), 32'd1);
    check("t4_done", 32'(done), 32'd0);
    check("t4_ar_cnt", 32'(ar_cnt), 32'd0);
    stop_cmd();

    // SLVERR on the fifth beat
    err_beat = 4;
    start_cmd(32'h4000, 32'd16, c0);
    wait_end("t5", 300);
    repeat (3) @(negedge clk);
    #2;
    check("t5_words", 32'(words), 32'd4);
    check("t5_data", 32'(data_bad), 32'd0);
    check("t5_beats_drained", 32'(gbeat), 32'd16);
    check("t5_error_held", 32'(error), 32'd1);
    check("t5_never_done", 32'(done_cyc), 32'hFFFF_FFFF);
    check("t5_ar_cnt", 32'(ar_cnt), 32'd1);
    err_beat = -1;
    stop_cmd();
    check("t5_error_clear", 32'(error), 32'd0);

    // abort after the third word, then a clean command
    begin
      bit got3 = 1'b0;
      start_cmd(32'h5000, 32'd32, c0);
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #2;
        if (words >= 3) begin got3 = 1'b1; break; end
      end
      resetn = 1'b0;
      check("t6_reached3", 32'(got3), 32'd1);
    end
    repeat (40) @(negedge clk);
    #2;
    check("t6_words", 32'(words), 32'd3);
    check("t6_beats_drained", 32'(gbeat), 32'd16);
    check("t6_ar_cnt", 32'(ar_cnt), 32'd1);
    check("t6_done", 32'(done), 32'd0);
    check("t6_error", 32'(error), 32'd0);
    start_cmd(32'h6000, 32'd5, c0);
    wait_end("t6b", 200);
    check("t6b_words", 32'(words), 32'd5);
    check("t6b_data", 32'(data_bad), 32'd0);
    check("t6b_ar_len", 32'(ar_len_log[0]), 32'd4);
    check("t6b_done", 32'(done), 32'd1);
    stop_cmd();

    // random valid/ready on every channel
    rand_mode = 1'b1;
    start_cmd(32'h7000, 32'd50, c0);
    wait_end("t7", 3000);
    check("t7_words", 32'(words), 32'd50);
    check("t7_data", 32'(data_bad), 32'd0);
    check("t7_ar_cnt", 32'(ar_cnt), 32'd4);
    check("t7_ar3_addr", ar_addr_log[3], 32'h70C0);
    check("t7_ar3_len", 32'(ar_len_log[3]), 32'd1);
    check("t7_ar_stable", 32'(stable_bad), 32'd0);
    check("t7_done", 32'(done), 32'd1);
    rand_mode = 1'b0;
    stop_cmd();

    check("glob_dv_without_beat", 32'(dv_bad), 32'd0);
    check("glob_done_and_error", 32'(both_bad), 32'd0);
    check("glob_ar_overlap", 32'(ar_overlap), 32'd0);
    check("glob_ar_format", 32'(ar_fmt_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
